// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the single integer register-file write port.
// In-order pipeline results and buffered long-latency results
// (divider, non-blocking loads) share the port. Long-latency results
// wait in a small circular queue. A starvation counter forces a queue
// slot, via stall_o, when the pipeline keeps winning the port.
module wb_arbiter #(
   parameter int XLEN       = 32,
   parameter int LQ_DEPTH   = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   // in-order pipeline writeback (no backpressure)
   input  logic                          pipe_we_i,
   input  logic [4:0]                    pipe_waddr_i,
   input  logic [XLEN-1:0]               pipe_wdata_i,
   // long-latency result handshake
   input  logic                          lat_valid_i,
   output logic                          lat_ready_o,
   input  logic [4:0]                    lat_waddr_i,
   input  logic [XLEN-1:0]               lat_wdata_i,
   // pipeline throttle
   output logic                          stall_o,
   // register-file write port
   output logic                          rf_we_o,
   output logic [4:0]                    rf_waddr_o,
   output logic [XLEN-1:0]               rf_wdata_o,
   // queue occupancy
   output logic [$clog2(LQ_DEPTH):0]     lq_count_o
);

   localparam int AW = $clog2(LQ_DEPTH);
   localparam int PW = AW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

   // Which source owns the write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_LQ   = 2'd2
   } src_e;

   // Pointers carry one extra wrap bit: equal pointers mean empty,
   // equal index with differing wrap bit means full.
   function automatic logic lq_is_full(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
      return (wr[PW-1] != rd[PW-1]) && (wr[AW-1:0] == rd[AW-1:0]);
   endfunction

   function automatic logic lq_is_empty(input logic [PW-1:0] wr, input logic [PW-1:0] rd);
      return wr == rd;
   endfunction

   // Queue storage
   logic [4:0]      lq_addr_q [LQ_DEPTH];
   logic [XLEN-1:0] lq_data_q [LQ_DEPTH];

   // State registers and next-state values
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            stall_q, stall_d;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

   // Combinational decode
   logic            pipe_req_s;
   logic            empty_s;
   logic            full_s;
   logic            lat_ready_s;
   logic            enq_s;
   logic            pop_s;
   src_e            src_s;
   logic [4:0]      head_addr_s;
   logic [XLEN-1:0] head_data_s;

   // Request qualification, queue status and handshake decode.
   always_comb begin
      pipe_req_s  = pipe_we_i && (pipe_waddr_i != 5'd0);
      empty_s     = lq_is_empty(wr_ptr_q, rd_ptr_q);
      full_s      = lq_is_full(wr_ptr_q, rd_ptr_q);
      lat_ready_s = !full_s && !rst_i;
      // x0 results complete the handshake but are never stored
      enq_s       = lat_valid_i && lat_ready_s && (lat_waddr_i != 5'd0);
      head_addr_s = lq_addr_q[rd_ptr_q[AW-1:0]];
      head_data_s = lq_data_q[rd_ptr_q[AW-1:0]];
   end

   // Port arbitration: a pending stall hands priority to the queue head,
   // otherwise the pipeline wins and the queue takes idle slots.
   always_comb begin
      src_s = SRC_NONE;
      if (stall_q && !empty_s) begin
         src_s = SRC_LQ;
      end else if (pipe_req_s) begin
         src_s = SRC_PIPE;
      end else if (!empty_s) begin
         src_s = SRC_LQ;
      end else begin
         src_s = SRC_NONE;
      end
      pop_s = (src_s == SRC_LQ);
   end

   // Pointer advance; a full queue refuses entry even if it pops now.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (enq_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Starvation tracking: count lost arbitrations of a waiting head,
   // raise stall the edge after the limit is seen, drop it on the pop.
   always_comb begin
      starve_d = starve_q;
      stall_d  = stall_q;
      if (empty_s || pop_s) begin
         starve_d = {SW{1'b0}};
      end else if ((src_s == SRC_PIPE) && (starve_q != STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
      if (pop_s) begin
         stall_d = 1'b0;
      end else if (starve_q == STARVE_LIMIT) begin
         stall_d = 1'b1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Write-port mux; address and data hold when nothing is written.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      case (src_s)
         SRC_PIPE: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_waddr_i;
            rf_wdata_d = pipe_wdata_i;
         end
         SRC_LQ: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_addr_s;
            rf_wdata_d = head_data_s;
         end
         default: begin
            rf_we_d    = 1'b0;
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
         end
      endcase
   end

   // Queue storage write; contents are don't-care once pointers reset.
   always_ff @(posedge clk_i) begin
      if (enq_s) begin
         lq_addr_q[wr_ptr_q[AW-1:0]] <= lat_waddr_i;
         lq_data_q[wr_ptr_q[AW-1:0]] <= lat_wdata_i;
      end
   end

   // Control state and registered outputs with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         starve_q   <= {SW{1'b0}};
         stall_q    <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= {XLEN{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign lat_ready_o = lat_ready_s;
   assign stall_o     = stall_q;
   assign rf_we_o     = rf_we_q;
   assign rf_waddr_o  = rf_waddr_q;
   assign rf_wdata_o  = rf_wdata_q;
   assign lq_count_o  = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a vector table for single-cycle behaviour, then
// hand-written multi-cycle sequences checked through per-source
// expected-write queues (pipe uses regs 16..31, long-latency regs 1..15).
module tb_wb_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        pipe_we_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        lat_valid_i;
   logic        lat_ready_o;
   logic [4:0]  lat_waddr_i;
   logic [31:0] lat_wdata_i;
   logic        stall_o;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic [2:0]  lq_count_o;

   wb_arbiter #(.XLEN(32), .LQ_DEPTH(4), .STARVE_MAX(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
      .lat_valid_i(lat_valid_i), .lat_ready_o(lat_ready_o),
      .lat_waddr_i(lat_waddr_i), .lat_wdata_i(lat_wdata_i),
      .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
      .rf_wdata_o(rf_wdata_o), .lq_count_o(lq_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        pw;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        ewe;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic [2:0]  ecnt;
   } vec_t;

   vec_t        vecs [12];
   int          n_checks = 0;
   int          n_err = 0;
   bit          sb_on = 1'b0;
   bit          last_acc;
   int          pcnt = 0;
   int          lcnt = 0;
   logic [36:0] exp_pipe [$];
   logic [36:0] exp_lat [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, record expected writes, end on next negedge.
   task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      pipe_we_i    = pw;
      pipe_waddr_i = pa;
      pipe_wdata_i = pd;
      lat_valid_i  = lv;
      lat_waddr_i  = la;
      lat_wdata_i  = ld;
      #1;
      last_acc = lv && lat_ready_o;
      if (sb_on) begin
         if (pw && pa != 5'd0) exp_pipe.push_back({pa, pd});
         if (last_acc && la != 5'd0) exp_lat.push_back({la, ld});
      end
      @(negedge clk_i);
   endtask

   // Cycle with auto-generated pipe / long-latency payloads.
   task automatic step(input logic pw, input logic lv);
      logic [4:0]  pa;
      logic [4:0]  la;
      pa = 5'd16 + 5'(pcnt % 16);
      la = 5'd1 + 5'(lcnt % 15);
      drive(pw, pa, 32'hB000_0000 + 32'(pcnt), lv, la, 32'hA000_0000 + 32'(lcnt));
      if (pw) pcnt++;
      if (last_acc) lcnt++;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (lq_count_o != 3'd0 && g < 30) begin
         step(1'b0, 1'b0);
         g++;
      end
      chk("drain_count", 32'(lq_count_o), 32'd0);
      step(1'b0, 1'b0);
   endtask

   // Scoreboard monitor: every register-file write must match the head
   // of the queue for its source.
   always @(negedge clk_i) begin
      logic [36:0] e;
      if (sb_on && rf_we_o) begin
         if (rf_waddr_o >= 5'd16) begin
            if (exp_pipe.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL sb_pipe_unexpected: got write %0d/%0h expected none", rf_waddr_o, rf_wdata_o);
            end else begin
               e = exp_pipe.pop_front();
               chk("sb_pipe_addr", 32'(rf_waddr_o), 32'(e[36:32]));
               chk("sb_pipe_data", rf_wdata_o, e[31:0]);
            end
         end else begin
            if (exp_lat.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL sb_lat_unexpected: got write %0d/%0h expected none", rf_waddr_o, rf_wdata_o);
            end else begin
               e = exp_lat.pop_front();
               chk("sb_lat_addr", 32'(rf_waddr_o), 32'(e[36:32]));
               chk("sb_lat_data", rf_wdata_o, e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hDEADBEEF, 3'd0};
      vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 3'd0};
      vecs[2]  = '{1'b0, 5'd9,  32'h00005555, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5,  32'hDEADBEEF, 3'd0};
      vecs[3]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd31, 32'hFFFFFFFF, 3'd0};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h11, 1'b0, 5'd31, 32'hFFFFFFFF, 3'd1};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7,  32'h00000011, 3'd0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h99, 1'b0, 5'd7,  32'h00000011, 3'd0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd7,  32'h00000011, 3'd0};
      vecs[8]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd9, 32'h99, 1'b1, 5'd3,  32'h00000033, 3'd1};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9,  32'h00000099, 3'd0};
      vecs[10] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd0, 32'h77, 1'b1, 5'd4,  32'h00000044, 3'd0};
      vecs[11] = '{1'b0, 5'd6,  32'h66,       1'b0, 5'd0, 32'h0,  1'b0, 5'd4,  32'h00000044, 3'd0};

      rst_i = 1'b1; pipe_we_i = 1'b0; pipe_waddr_i = 5'd0; pipe_wdata_i = 32'd0;
      lat_valid_i = 1'b0; lat_waddr_i = 5'd0; lat_wdata_i = 32'd0;
      repeat (2) @(negedge clk_i);
      chk("rst_we", 32'(rf_we_o), 32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
      chk("rst_wdata", rf_wdata_o, 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_count", 32'(lq_count_o), 32'd0);
      chk("rst_ready", 32'(lat_ready_o), 32'd0);
      rst_i = 1'b0;
      #1;
      chk("ready_after_rst", 32'(lat_ready_o), 32'd1);
      @(negedge clk_i);

      // Table of single-cycle behaviours
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].pw, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
         chk($sformatf("vec%0d_we", i), 32'(rf_we_o), 32'(vecs[i].ewe));
         chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr_o), 32'(vecs[i].ea));
         chk($sformatf("vec%0d_wdata", i), rf_wdata_o, vecs[i].ed);
         chk($sformatf("vec%0d_count", i), 32'(lq_count_o), 32'(vecs[i].ecnt));
      end

      sb_on = 1'b1;

      // Fill under a continuous pipe stream; fifth entry must wait.
      for (int c = 0; c < 40; c++) begin
         step(!stall_o, (lcnt < 5));
         if (c == 3) begin
            chk("fill_count4", 32'(lq_count_o), 32'd4);
            chk("fill_ready0", 32'(lat_ready_o), 32'd0);
         end
         if (c > 3 && c < 9) chk("fill_held", 32'(lq_count_o), 32'd4);
         if (c == 9) chk("fill_stall", 32'(stall_o), 32'd1);
      end
      drain();
      chk("fill_all_accepted", 32'(lcnt), 32'd5);

      // Fill to full, then push while popping across pointer wrap.
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
      chk("wrap_full", 32'(lq_count_o), 32'd4);
      for (int c = 0; c < 21; c++) begin
         step(1'b0, 1'b1);
         chk("wrap_count", 32'(lq_count_o), 32'd3);
      end
      drain();

      // Starvation: one queued entry behind a continuous pipe stream.
      step(1'b1, 1'b1);
      n = 0;
      while (!stall_o && n < 30) begin
         step(1'b1, 1'b0);
         n++;
      end
      chk("starve_cycles", 32'(n), 32'd9);
      chk("starve_count", 32'(lq_count_o), 32'd1);
      step(1'b0, 1'b0);
      chk("starve_pop_we", 32'(rf_we_o), 32'd1);
      chk("starve_pop_addr", 32'(rf_waddr_o), 32'(5'd1 + 5'((lcnt - 1) % 15)));
      chk("starve_stall_clr", 32'(stall_o), 32'd0);
      chk("starve_count0", 32'(lq_count_o), 32'd0);

      // Reset with three entries queued and stall raised.
      for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
      n = 0;
      while (!stall_o && n < 30) begin
         step(1'b1, 1'b0);
         n++;
      end
      chk("rstq_stall", 32'(stall_o), 32'd1);
      chk("rstq_count", 32'(lq_count_o), 32'd3);
      rst_i = 1'b1;
      exp_lat.delete();
      step(1'b0, 1'b1);
      chk("rstq_noacc", 32'(last_acc), 32'd0);
      chk("rstq_ready", 32'(lat_ready_o), 32'd0);
      chk("rstq_we", 32'(rf_we_o), 32'd0);
      chk("rstq_waddr", 32'(rf_waddr_o), 32'd0);
      chk("rstq_wdata", rf_wdata_o, 32'd0);
      chk("rstq_stall0", 32'(stall_o), 32'd0);
      chk("rstq_count0", 32'(lq_count_o), 32'd0);
      rst_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step(1'b0, 1'b0);
         chk("post_rst_count", 32'(lq_count_o), 32'd0);
      end

      chk("sb_pipe_left", 32'(exp_pipe.size()), 32'd0);
      chk("sb_lat_left", 32'(exp_lat.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter that owns the single write port of the integer register file. It merges in-order pipeline results with out-of-order long-latency results (divider, non-blocking loads) that arrive on a valid/ready handshake and are buffered in a small FIFO. It also prevents the FIFO from starving behind a continuous pipeline write stream. It sits at the end of the writeback stage and drives the register file's write enable, address and data directly.

## Interface

- XLEN, 32, data width
- LQ_DEPTH, 4, long-latency queue depth (power of two, ≥2)
- STARVE_MAX, 8, consecutive lost arbitrations before the queue forces a slot
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- pipe_we_i  in  1  in-order writeback request (no backpressure)
- pipe_waddr_i  in  5  destination register
- pipe_wdata_i  in  XLEN  result data
- lat_valid_i  in  1  long-latency result valid
- lat_ready_o  out  1  queue can accept (= !full && !rst_i)
- lat_waddr_i  in  5  long-latency destination
- lat_wdata_i  in  XLEN  long-latency data
- stall_o  out  1  registered; requests the pipeline to suppress pipe_we_i next cycle
- rf_we_o  out  1  registered register-file write enable
- rf_waddr_o  out  5  registered write address
- rf_wdata_o  out  XLEN  registered write data
- lq_count_o  out  $clog2(LQ_DEPTH)+1  current queue occupancy

## Operation

- Effective pipe request: pipe_we_i && pipe_waddr_i != 0. Writes to x0 are dropped and do not consume the port.
- Enqueue on lat_valid_i && lat_ready_o. If lat_waddr_i == 0, the handshake completes and the entry is discarded (not stored).
- Queue is a circular buffer. Read/write pointers are $clog2(LQ_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal. lat_ready_o uses occupancy at cycle start. On full, no enqueue occurs, even if a pop happens in the same cycle.
- Arbitration each cycle:
  - effective pipe request wins;
  - else, if the queue is non-empty, pop the head;
  - else, rf_we_o = 0 next cycle.
- The selected source is registered into rf_*; rf_waddr_o/rf_wdata_o hold their last value when rf_we_o = 0.
- Occupancy: enqueue-only +1, pop-only −1, both or neither 0.
- Starvation counter (0..STARVE_MAX):
  - clears when the queue is empty or the head pops;
  - increments when the queue is non-empty and the pipe wins.
  - When it reaches STARVE_MAX, stall_o is set at the next edge.
- While stall_o = 1:
  - the queue head has priority over the pipe;
  - stall_o clears at the edge the head pops.
  - If pipe_we_i is still asserted (contract violation), that pipe write is lost. Verification flags this as a bench error; the RTL need not detect it.

## Timing

- Reset (rst_i sampled high at an edge):
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0;
  - stall_o = 0, pointers = 0, lq_count_o = 0, starvation counter = 0.
- lat_ready_o is 0 in any cycle with rst_i = 1. Reset mid-operation discards all queued entries.
- Pipe → rf_we_o: 1 cycle.
- Long-latency → rf_we_o: minimum 2 cycles (enqueue edge, then pop edge). There is no bypass.
- stall_o asserts 1 cycle after the counter reaches STARVE_MAX. The pop occurs in the first stall_o = 1 cycle. stall_o deasserts at the following edge.
- Sustained throughput: one register-file write per cycle.
- Simultaneous same-address pipe and queue entries are not merged. Write order equals arbitration order.

## Test plan

- Reset, then pipe_we_i = 1, waddr = 5, wdata = 0xDEADBEEF, one cycle → next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF. pipe waddr = 0 → rf_we_o = 0.
- Idle pipe; lat_valid_i with (7, 0x11) at cycle 0 → lq_count_o = 1 at cycle 1; rf_we_o = 1, waddr = 7, data = 0x11 at cycle 2; lq_count_o back to 0.
- Pipe writing every cycle; push 4 entries (regs 1..4) → lq_count_o = 4, lat_ready_o = 0. A fifth valid is held (not accepted) until occupancy drops. No data loss or reorder.
- Continuous pipe writes with 1 queued entry → stall_o = 1 after 8 lost arbitrations plus 1 cycle. The bench drops pipe_we_i; the queued entry writes next cycle; stall_o returns to 0.
- Fill the queue to 4, then pop and push simultaneously for 20 cycles (pointer wrap) → occupancy stays constant, FIFO order preserved across wrap.
- Assert rst_i with 3 entries queued and stall_o = 1 → after the reset edge, all outputs are 0 and lq_count_o = 0. After rst_i drops, no stale entry is ever written.
